// File: rtl/serial_in_parallel_out_sipo_8_bit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_in_parallel_out_sipo_8_bit
//  Brief    : Serial-in/parallel-out shift register with word-complete pulse
//             and in-word bit counter.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out_sipo_8_bit #(
  parameter int               WIDTH       = 8,
  parameter int               SHIFT_LEFT  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  input  logic                     Serial_Data_In,
  output logic [WIDTH-1:0]         SIPO_Shift_Register,
  output logic                     Word_Valid,
  output logic [$clog2(WIDTH)-1:0] Bit_Count
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_next;
  logic             word_done;

  generate
    if (SHIFT_LEFT != 0) begin : g_shift_left
      assign shift_next = {SIPO_Shift_Register[WIDTH-2:0], Serial_Data_In};
    end else begin : g_shift_right
      assign shift_next = {Serial_Data_In, SIPO_Shift_Register[WIDTH-1:1]};
    end
  endgenerate

  // Counter and pulse depend only on the edge count, so an X data bit
  // can never leak into the framing outputs.
  assign word_done = (Bit_Count == LAST_BIT);

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      SIPO_Shift_Register <= RESET_VALUE;
      Bit_Count           <= '0;
      Word_Valid          <= 1'b0;
    end else begin
      SIPO_Shift_Register <= shift_next;
      Bit_Count           <= word_done ? '0 : Bit_Count + CNT_W'(1);
      Word_Valid          <= word_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_in_parallel_out_sipo_8_bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_in_parallel_out_sipo_8_bit
//  Brief    : Directed bench for the SIPO register, left- and right-shift builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_in_parallel_out_sipo_8_bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sdi;
  logic [7:0] reg_l, reg_r;
  logic       valid_l, valid_r;
  logic [2:0] cnt_l, cnt_r;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_in_parallel_out_sipo_8_bit #(.WIDTH(8), .SHIFT_LEFT(1), .RESET_VALUE(8'h00)) dut_left (
    .Clk_In(clk), .Reset_In(rst_n), .Serial_Data_In(sdi),
    .SIPO_Shift_Register(reg_l), .Word_Valid(valid_l), .Bit_Count(cnt_l)
  );

  serial_in_parallel_out_sipo_8_bit #(.WIDTH(8), .SHIFT_LEFT(0), .RESET_VALUE(8'h00)) dut_right (
    .Clk_In(clk), .Reset_In(rst_n), .Serial_Data_In(sdi),
    .SIPO_Shift_Register(reg_r), .Word_Valid(valid_r), .Bit_Count(cnt_r)
  );

  // Drive one bit, let the next rising edge sample it, observe 1 ns later.
  task automatic shift_bit(input logic b);
    sdi = b;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    hold_reset();
    release_reset();
  endtask

  task automatic test_reset();
    sdi   = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    hold_reset();
    vectors++; if (reg_l !== 8'h00) begin miscompares++; $display("FAIL reset_reg_left: got %h expected 00", reg_l); end
    vectors++; if (reg_r !== 8'h00) begin miscompares++; $display("FAIL reset_reg_right: got %h expected 00", reg_r); end
    vectors++; if (cnt_l !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", cnt_l); end
    vectors++; if (valid_l !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_l); end
    @(posedge clk);
    #1;
    vectors++; if (reg_l !== 8'h00 || cnt_l !== 3'd0) begin
      miscompares++; $display("FAIL reset_held: got reg %h cnt %0d expected 00 0", reg_l, cnt_l);
    end
    release_reset();
  endtask

  task automatic test_pattern();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      shift_bit(bits[7-i]);
      vectors++; if (cnt_l !== 3'((i + 1) % 8)) begin
        miscompares++; $display("FAIL pattern_count[%0d]: got %0d expected %0d", i, cnt_l, (i + 1) % 8);
      end
      vectors++; if (valid_l !== (i == 7)) begin
        miscompares++; $display("FAIL pattern_valid[%0d]: got %b expected %b", i, valid_l, i == 7);
      end
    end
    vectors++; if (reg_l !== 8'hB2) begin miscompares++; $display("FAIL pattern_word_left: got %h expected b2", reg_l); end
    vectors++; if (reg_r !== 8'h4D) begin miscompares++; $display("FAIL pattern_word_right: got %h expected 4d", reg_r); end
    vectors++; if (valid_r !== 1'b1) begin miscompares++; $display("FAIL pattern_valid_right: got %b expected 1", valid_r); end
    shift_bit(1'b0);
    vectors++; if (valid_l !== 1'b0) begin miscompares++; $display("FAIL pattern_pulse_width: got %b expected 0", valid_l); end
  endtask

  task automatic test_walking();
    logic [7:0] expected;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      shift_bit(i == 1);
      expected = 8'h01 << (i - 1);
      vectors++; if (reg_l !== expected) begin
        miscompares++; $display("FAIL walking_reg[%0d]: got %h expected %h", i, reg_l, expected);
      end
      vectors++; if (cnt_l !== 3'(i % 8)) begin
        miscompares++; $display("FAIL walking_count[%0d]: got %0d expected %0d", i, cnt_l, i % 8);
      end
    end
  endtask

  task automatic test_stream();
    logic [23:0] stream;
    int          pulses;
    int          last;
    stream = 24'hA5_3C_E1;
    pulses = 0;
    last   = -100;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      shift_bit(stream[23-i]);
      vectors++; if (valid_l !== ((i % 8) == 7)) begin
        miscompares++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, valid_l, (i % 8) == 7);
      end
      if (valid_l === 1'b1) begin
        pulses++;
        vectors++; if (reg_l !== stream[(2 - i / 8) * 8 +: 8]) begin
          miscompares++; $display("FAIL stream_word[%0d]: got %h expected %h", i, reg_l, stream[(2 - i / 8) * 8 +: 8]);
        end
        if (pulses > 1) begin
          vectors++; if (i - last != 8) begin
            miscompares++; $display("FAIL stream_spacing[%0d]: got %0d expected 8", i, i - last);
          end
        end
        last = i;
      end
    end
    vectors++; if (pulses != 3) begin miscompares++; $display("FAIL stream_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    hold_reset();
    vectors++; if (cnt_l !== 3'd0 || reg_l !== 8'h00 || valid_l !== 1'b0) begin
      miscompares++; $display("FAIL midword_reset: got reg %h cnt %0d valid %b expected 00 0 0", reg_l, cnt_l, valid_l);
    end
    release_reset();
    for (int i = 0; i < 8; i++) begin
      shift_bit(1'b1);
      vectors++; if (valid_l !== (i == 7)) begin
        miscompares++; $display("FAIL midword_valid[%0d]: got %b expected %b", i, valid_l, i == 7);
      end
    end
    vectors++; if (reg_l !== 8'hFF) begin miscompares++; $display("FAIL midword_word: got %h expected ff", reg_l); end
    // Reset during the pulse cycle must clear the pulse without waiting for an edge.
    rst_n = 1'b0;
    #1;
    vectors++; if (valid_l !== 1'b0 || reg_l !== 8'h00) begin
      miscompares++; $display("FAIL async_drop: got valid %b reg %h expected 0 00", valid_l, reg_l);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_x_input();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      shift_bit((i < 3) ? 1'bx : 1'b0);
      vectors++; if (cnt_l !== 3'((i + 1) % 8)) begin
        miscompares++; $display("FAIL xin_count[%0d]: got %b expected %0d", i, cnt_l, (i + 1) % 8);
      end
      vectors++; if (valid_l !== (i == 7)) begin
        miscompares++; $display("FAIL xin_valid[%0d]: got %b expected %b", i, valid_l, i == 7);
      end
    end
  endtask

  task automatic test_shift_right();
    do_reset();
    for (int i = 0; i < 8; i++) shift_bit(i == 0);
    vectors++; if (reg_r !== 8'h01) begin miscompares++; $display("FAIL right_word: got %h expected 01", reg_r); end
    vectors++; if (valid_r !== 1'b1) begin miscompares++; $display("FAIL right_valid: got %b expected 1", valid_r); end
    vectors++; if (cnt_r !== 3'd0) begin miscompares++; $display("FAIL right_count: got %0d expected 0", cnt_r); end
    vectors++; if (reg_l !== 8'h80) begin miscompares++; $display("FAIL right_vs_left: got %h expected 80", reg_l); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_walking();
    test_stream();
    test_reset_mid_word();
    test_x_input();
    test_shift_right();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
